// File: rtl/array_regpx_nrd.sv
// Single-clock parity register array: NRD registered read ports, per-port sticky parity errors,
// first-error address/port capture and a saturating error counter.
// Define ARRAY_REGPX_NRD_SCRUB_EN to build the background scrubber (reports as port NRD).
//   state | meaning
//   IDLE  | scrubber parked, pointer held
//   SCAN  | each we=0 cycle checks array[ptr] and advances ptr, wrapping DEPTH-1 to 0
module array_regpx_nrd #(
  parameter int ADDRBIT  = 9,
  parameter int DEPTH    = 512,
  parameter int WIDTH    = 32,
  parameter int NRD      = 2,
  parameter int ERRCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [ADDRBIT-1:0]     wa,
  input  logic [WIDTH-1:0]       di,
  input  logic [NRD*ADDRBIT-1:0] ra,
  output logic [NRD*WIDTH-1:0]   dout,
  input  logic [1:0]             par_ctrl,
  input  logic                   scrub_en,
  output logic [NRD:0]           par_err_vec,
  output logic                   par_err,
  output logic [ADDRBIT-1:0]     err_addr,
  output logic [2:0]             err_port,
  output logic [ERRCNT_W-1:0]    err_cnt
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRBIT:0] DEPTH_C = (ADDRBIT+1)'(DEPTH);

  logic [WIDTH-1:0]   mem_data [DEPTH];
  logic               mem_par  [DEPTH];
  logic               wr_ok;
  logic [NRD:0]       det;
  logic [ADDRBIT-1:0] det_addr [NRD+1];
  logic [2:0]         sel_port;
  logic [ADDRBIT-1:0] sel_addr;

  assign wr_ok = we && ({1'b0, wa} < DEPTH_C);

  // par_ctrl[1] freezes the stored parity so a write can plant a deliberate error
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_par[i]  <= 1'b0;
      end
    end else if (wr_ok) begin
      mem_data[wa[IW-1:0]] <= di;
      if (!par_ctrl[1]) mem_par[wa[IW-1:0]] <= ^di;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDRBIT-1:0] ra_k, a1_q, a2_q;
    logic [WIDTH-1:0]   d1_q;
    logic               p1_q, v1_q, det_q, ra_ok;

    assign ra_k  = ra[k*ADDRBIT +: ADDRBIT];
    assign ra_ok = ({1'b0, ra_k} < DEPTH_C);

    always_ff @(posedge clk) begin
      if (rst) begin
        d1_q  <= '0;
        p1_q  <= 1'b0;
        v1_q  <= 1'b0;
        a1_q  <= '0;
        det_q <= 1'b0;
        a2_q  <= '0;
      end else begin
        v1_q  <= ra_ok;
        d1_q  <= ra_ok ? mem_data[ra_k[IW-1:0]] : '0;
        p1_q  <= ra_ok ? mem_par[ra_k[IW-1:0]] : 1'b0;
        a1_q  <= ra_k;
        det_q <= v1_q && ((^d1_q) != p1_q);
        a2_q  <= a1_q;
      end
    end

    assign dout[k*WIDTH +: WIDTH] = d1_q;
    assign det[k]                 = det_q;
    assign det_addr[k]            = a2_q;
  end

`ifdef ARRAY_REGPX_NRD_SCRUB_EN
  typedef enum logic {S_IDLE = 1'b0, S_SCAN = 1'b1} scr_state_t;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  scr_state_t       state_q, state_d;
  logic             scan_rd;
  logic [IW-1:0]    ptr_q, sa1_q, sa2_q;
  logic [WIDTH-1:0] sd1_q;
  logic             sp1_q, sv1_q, sdet_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (scrub_en)  state_d = S_SCAN;
      S_SCAN:  if (!scrub_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // a write cycle stalls the scan so the pointer never skips a word
  always_comb scan_rd = (state_q == S_SCAN) && !we;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      sv1_q  <= 1'b0;
      sd1_q  <= '0;
      sp1_q  <= 1'b0;
      sa1_q  <= '0;
      sdet_q <= 1'b0;
      sa2_q  <= '0;
    end else begin
      sv1_q  <= scan_rd;
      sd1_q  <= mem_data[ptr_q];
      sp1_q  <= mem_par[ptr_q];
      sa1_q  <= ptr_q;
      sdet_q <= sv1_q && ((^sd1_q) != sp1_q);
      sa2_q  <= sa1_q;
      if (scan_rd) ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + IW'(1);
    end
  end

  assign det[NRD]      = sdet_q;
  assign det_addr[NRD] = ADDRBIT'(sa2_q);
`else
  logic unused_scrub;
  assign unused_scrub  = scrub_en;
  assign det[NRD]      = 1'b0;
  assign det_addr[NRD] = '0;
`endif

  // descending scan leaves the lowest flagged source selected
  always_comb begin
    sel_port = '0;
    sel_addr = '0;
    for (int k = NRD; k >= 0; k--) begin
      if (det[k]) begin
        sel_port = 3'(k);
        sel_addr = det_addr[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || par_ctrl[0]) begin
      par_err_vec <= '0;
      err_addr    <= '0;
      err_port    <= '0;
      err_cnt     <= '0;
    end else if (|det) begin
      par_err_vec <= par_err_vec | det;
      if (par_err_vec == '0) begin
        err_addr <= sel_addr;
        err_port <= sel_port;
      end
      if (err_cnt != '1) err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end

  assign par_err = |par_err_vec;

endmodule

// File: tb/tb_array_regpx_nrd.sv
// Self-checking bench for array_regpx_nrd: random traffic against an event-queue reference model
// plus directed read-during-write, injection, priority, clear, saturation, reset and scrub scenarios.
module tb_array_regpx_nrd;
  localparam int AB = 5, DP = 16, W = 32, N = 2, CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst, we, par_err, scrub_en;
  logic [AB-1:0]     wa, err_addr;
  logic [W-1:0]      di;
  logic [N*AB-1:0]   ra;
  logic [N*W-1:0]    dout;
  logic [1:0]        par_ctrl;
  logic [N:0]        par_err_vec;
  logic [2:0]        err_port;
  logic [CW-1:0]     err_cnt;

  int checks = 0, failures = 0, cyc = 0;

  typedef struct {int due; int port; int addr;} ev_t;
  ev_t        evq[$];
  logic [W-1:0] ref_data [DP];
  bit           ref_par  [DP];
  logic [N:0]   m_vec;
  int           m_addr, m_port, m_cnt, m_ptr;
  bit           m_scan;
  logic [W-1:0] m_dout [N];

  array_regpx_nrd #(.ADDRBIT(AB), .DEPTH(DP), .WIDTH(W), .NRD(N), .ERRCNT_W(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .di(di), .ra(ra), .dout(dout),
    .par_ctrl(par_ctrl), .scrub_en(scrub_en), .par_err_vec(par_err_vec), .par_err(par_err),
    .err_addr(err_addr), .err_port(err_port), .err_cnt(err_cnt));

  always #5 clk = ~clk;

  // One clock edge: the model applies the spec's rules to the inputs seen at that edge.
  task automatic tick();
    ev_t keep[$];
    logic [N:0] hit;
    int fp, fa, a;
    @(posedge clk);
    cyc++;
    if (rst) begin
      for (int i = 0; i < DP; i++) begin ref_data[i] = '0; ref_par[i] = 1'b0; end
      evq.delete();
      m_vec = '0; m_addr = 0; m_port = 0; m_cnt = 0; m_ptr = 0; m_scan = 1'b0;
      for (int k = 0; k < N; k++) m_dout[k] = '0;
    end else begin
      hit = '0; fp = 99; fa = 0;
      foreach (evq[i]) begin
        if (evq[i].due == cyc) begin
          hit[evq[i].port] = 1'b1;
          if (evq[i].port < fp) begin fp = evq[i].port; fa = evq[i].addr; end
        end else keep.push_back(evq[i]);
      end
      evq = keep;
      if (par_ctrl[0]) begin
        m_vec = '0; m_addr = 0; m_port = 0; m_cnt = 0;
      end else if (hit != '0) begin
        if (m_vec == '0) begin m_addr = fa; m_port = fp; end
        m_vec = m_vec | hit;
        if (m_cnt < CMAX) m_cnt++;
      end
      for (int k = 0; k < N; k++) begin
        a = int'(ra[k*AB +: AB]);
        if (a < DP) begin
          m_dout[k] = ref_data[a];
          if ((^ref_data[a]) != ref_par[a]) evq.push_back('{cyc + 2, k, a});
        end else m_dout[k] = '0;
      end
`ifdef ARRAY_REGPX_NRD_SCRUB_EN
      if (m_scan && !we) begin
        if ((^ref_data[m_ptr]) != ref_par[m_ptr]) evq.push_back('{cyc + 2, N, m_ptr});
        m_ptr = (m_ptr + 1) % DP;
      end
      m_scan = scrub_en;
`endif
      if (we && int'(wa) < DP) begin
        ref_data[wa] = di;
        if (!par_ctrl[1]) ref_par[wa] = ^di;
      end
    end
    #1;
  endtask

  task automatic quiesce();
    we = 1'b0; ra = {5'd31, 5'd31}; par_ctrl = 2'b00; scrub_en = 1'b0;
    tick(); tick(); tick();
    par_ctrl = 2'b01; tick(); par_ctrl = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; wa = '0; di = '0; ra = {5'd31, 5'd31}; par_ctrl = 2'b00; scrub_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (dout !== '0) begin failures++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (par_err_vec !== '0) begin failures++; $display("FAIL reset_vec got=%b exp=0", par_err_vec); end
    checks++; if (err_addr !== '0 || err_port !== '0) begin failures++; $display("FAIL reset_capture got=%0d/%0d exp=0/0", err_addr, err_port); end
    checks++; if (err_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", err_cnt); end
    for (int i = 0; i < DP + 4; i++) begin
      ra = {AB'((i + 7) % (DP + 4)), AB'(i)};
      tick();
      checks++; if (dout !== '0) begin failures++; $display("FAIL reset_read addr=%0d got=%h exp=0", i, dout); end
      checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL reset_read_err addr=%0d got=%b/%0d exp=0/0", i, par_err, err_cnt); end
    end
    ra = {5'd31, 5'd31}; tick(); tick();
    checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL reset_tail got=%b/%0d exp=0/0", par_err, err_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 350; i++) begin
      we = 1'(($urandom_range(0, 1)));
      wa = AB'($urandom_range(0, 31));
      di = $urandom;
      ra = {AB'($urandom_range(0, 31)), AB'($urandom_range(0, 31))};
      par_ctrl = (i < 150) ? 2'b00 : {($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0)};
      tick();
      for (int k = 0; k < N; k++) begin
        checks++;
        if (dout[k*W +: W] !== m_dout[k]) begin failures++; $display("FAIL rand_dout%0d cyc=%0d got=%h exp=%h", k, cyc, dout[k*W +: W], m_dout[k]); end
      end
      checks++; if (par_err_vec !== m_vec || par_err !== (m_vec != '0)) begin failures++; $display("FAIL rand_vec cyc=%0d got=%b exp=%b", cyc, par_err_vec, m_vec); end
      checks++; if (err_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, m_cnt); end
      checks++; if (err_addr !== AB'(m_addr) || err_port !== 3'(m_port)) begin failures++; $display("FAIL rand_capture cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, err_addr, err_port, m_addr, m_port); end
    end
  endtask

  task automatic test_rdw();
    quiesce();
    we = 1'b1; wa = 5'd5; di = 32'h0; tick();
    di = 32'h12345678; ra = {5'd31, 5'd5}; tick();
    we = 1'b0;
    checks++; if (dout[W-1:0] !== 32'h0) begin failures++; $display("FAIL rdw_old got=%h exp=00000000", dout[W-1:0]); end
    tick();
    checks++; if (dout[W-1:0] !== 32'h12345678) begin failures++; $display("FAIL rdw_new got=%h exp=12345678", dout[W-1:0]); end
    ra = {5'd31, 5'd31}; tick(); tick();
    checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL rdw_clean got=%b/%0d exp=0/0", par_err, err_cnt); end
  endtask

  task automatic test_inject();
    quiesce();
    we = 1'b1; wa = 5'd7; di = 32'h1; tick();
    par_ctrl = 2'b10; di = 32'h3; tick();
    par_ctrl = 2'b00; we = 1'b0;
    ra = {5'd7, 5'd31}; tick();
    ra = {5'd31, 5'd31};
    checks++; if (dout[2*W-1:W] !== 32'h3 || par_err !== 1'b0) begin failures++; $display("FAIL inj_edgeN got=%h/%b exp=3/0", dout[2*W-1:W], par_err); end
    tick();
    checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL inj_early got=%b exp=0", par_err); end
    tick();
    checks++; if (par_err_vec !== 3'b010) begin failures++; $display("FAIL inj_vec got=%b exp=010", par_err_vec); end
    checks++; if (err_addr !== 5'd7 || err_port !== 3'd1) begin failures++; $display("FAIL inj_capture got=%0d/%0d exp=7/1", err_addr, err_port); end
    checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL inj_cnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_simultaneous();
    quiesce();
    we = 1'b1; wa = 5'd3; di = 32'h2; tick();
    par_ctrl = 2'b10; di = 32'h3; tick();
    par_ctrl = 2'b00; we = 1'b0;
    ra = {5'd7, 5'd3}; tick();
    ra = {5'd31, 5'd31}; tick(); tick();
    checks++; if (err_port !== 3'd0 || err_addr !== 5'd3) begin failures++; $display("FAIL simul_capture got=%0d/%0d exp=0/3", err_port, err_addr); end
    checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL simul_cnt got=%0d exp=1", err_cnt); end
    checks++; if (par_err_vec !== 3'b011) begin failures++; $display("FAIL simul_vec got=%b exp=011", par_err_vec); end
    par_ctrl = 2'b01; tick(); par_ctrl = 2'b00;
    ra = {5'd31, 5'd3}; tick();
    ra = {5'd31, 5'd31}; tick();
    par_ctrl = 2'b01; tick(); par_ctrl = 2'b00;
    checks++; if (par_err_vec !== '0 || err_cnt !== '0) begin failures++; $display("FAIL clear_wins got=%b/%0d exp=000/0", par_err_vec, err_cnt); end
    checks++; if (err_addr !== '0 || err_port !== '0) begin failures++; $display("FAIL clear_capture got=%0d/%0d exp=0/0", err_addr, err_port); end
    tick();
    checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL clear_after got=%b/%0d exp=0/0", par_err, err_cnt); end
  endtask

  task automatic test_saturation();
    quiesce();
    for (int i = 0; i < 20; i++) begin
      ra = {5'd7, (i >= 5 && i < 10) ? 5'd3 : 5'd31};
      tick();
      checks++; if (err_cnt !== CW'(m_cnt)) begin failures++; $display("FAIL sat_step i=%0d got=%0d exp=%0d", i, err_cnt, m_cnt); end
    end
    ra = {5'd31, 5'd31}; tick(); tick(); tick();
    checks++; if (err_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", err_cnt); end
    checks++; if (err_addr !== 5'd7 || err_port !== 3'd1) begin failures++; $display("FAIL sat_capture got=%0d/%0d exp=7/1", err_addr, err_port); end
    checks++; if (par_err_vec !== 3'b011) begin failures++; $display("FAIL sat_vec got=%b exp=011", par_err_vec); end
  endtask

  task automatic test_rst_midflight();
    quiesce();
    ra = {5'd7, 5'd31}; tick();
    ra = {5'd31, 5'd31}; rst = 1'b1; tick();
    rst = 1'b0; tick(); tick();
    checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL rst_inflight got=%b/%0d exp=0/0", par_err, err_cnt); end
    checks++; if (dout !== '0) begin failures++; $display("FAIL rst_dout got=%h exp=0", dout); end
    ra = {5'd7, 5'd7}; tick();
    ra = {5'd31, 5'd31}; tick(); tick();
    checks++; if (par_err !== 1'b0 || err_cnt !== '0) begin failures++; $display("FAIL rst_array_clean got=%b/%0d exp=0/0", par_err, err_cnt); end
  endtask

`ifdef ARRAY_REGPX_NRD_SCRUB_EN
  task automatic test_scrub();
    bit seen = 1'b0;
    quiesce();
    we = 1'b1; wa = 5'd9; di = 32'h1; tick();
    par_ctrl = 2'b10; di = 32'h3; tick();
    par_ctrl = 2'b00; we = 1'b0; wa = 5'd31;
    scrub_en = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (par_err_vec[N]) seen = 1'b1;
    end
    checks++; if (!seen) begin failures++; $display("FAIL scrub_timeout got=%b exp=1", par_err_vec[N]); end
    checks++; if (err_addr !== 5'd9 || err_port !== 3'(N)) begin failures++; $display("FAIL scrub_capture got=%0d/%0d exp=9/%0d", err_addr, err_port, N); end
    checks++; if (par_err_vec !== 3'b100 || err_cnt !== 4'd1) begin failures++; $display("FAIL scrub_first got=%b/%0d exp=100/1", par_err_vec, err_cnt); end
    for (int i = 0; i < 120; i++) begin
      we = ($urandom_range(0, 3) == 0);
      di = $urandom;
      scrub_en = (i < 100);
      tick();
      checks++; if (err_cnt !== CW'(m_cnt) || par_err_vec !== m_vec) begin failures++; $display("FAIL scrub_walk cyc=%0d got=%0d/%b exp=%0d/%b", cyc, err_cnt, par_err_vec, m_cnt, m_vec); end
    end
    we = 1'b0; scrub_en = 1'b0;
  endtask
`else
  task automatic test_no_scrub();
    quiesce();
    we = 1'b1; wa = 5'd9; di = 32'h1; tick();
    par_ctrl = 2'b10; di = 32'h3; tick();
    par_ctrl = 2'b00; we = 1'b0;
    scrub_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++; if (par_err_vec !== '0 || err_cnt !== '0) begin failures++; $display("FAIL no_scrub i=%0d got=%b/%0d exp=000/0", i, par_err_vec, err_cnt); end
    end
    scrub_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_random();
    test_rdw();
    test_inject();
    test_simultaneous();
    test_saturation();
    test_rst_midflight();
`ifdef ARRAY_REGPX_NRD_SCRUB_EN
    test_scrub();
`else
    test_no_scrub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
